pc_redirect_controller: RTL and testbench

//  Sequences control-flow redirects produced by branch_decoder_unit (pc_src) and by traps.

---
 rtl/branch_decoder_unit_pkg.sv | 11 +
 rtl/pc_redirect_controller_pkg.sv | 20 ++
 rtl/redirect_target_mux.sv | 31 +++
 rtl/pc_redirect_controller.sv | 181 ++++++++++++++++++
 tb/tb_pc_redirect_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_decoder_unit_pkg.sv
// Shared control-flow source encoding produced by the EX-stage branch decoder.
package branch_decoder_unit_pkg;

  typedef enum logic [1:0] {
    PcPlus4,
    PcOrReadDataPlusImm,
    Mepc,
    Sepc
  } pc_src_t;

endpackage

// File: rtl/pc_redirect_controller_pkg.sv
// Types and helpers for the PC redirect controller.
package pc_redirect_controller_pkg;

  import branch_decoder_unit_pkg::*;

  typedef enum logic [1:0] {
    Idle,
    Redirect,
    Drain
  } state_t;

  localparam int unsigned DrainCntWidth = 4;

  // A not-taken resolve is the only resolve that leaves the fetch stream alone.
  function automatic logic is_redirect_event(logic trap_req, logic resolve_valid,
                                             pc_src_t pc_src);
    return trap_req | (resolve_valid & (pc_src != PcPlus4));
  endfunction

endpackage

// File: rtl/redirect_target_mux.sv
// Priority selection of the redirect target: trap vector first, then the decoder's choice.
module redirect_target_mux
  import branch_decoder_unit_pkg::*;
#(
  parameter int unsigned Width = 64
) (
  input  logic             trap_req_i,
  input  pc_src_t          pc_src_i,
  input  logic [Width-1:0] pc_plus_4_i,
  input  logic [Width-1:0] branch_target_i,
  input  logic [Width-1:0] mepc_i,
  input  logic [Width-1:0] sepc_i,
  input  logic [Width-1:0] trap_vector_i,
  output logic [Width-1:0] target_o
);

  always_comb begin
    target_o = pc_plus_4_i;
    if (trap_req_i) begin
      target_o = trap_vector_i;
    end else begin
      case (pc_src_i)
        Mepc:                target_o = mepc_i;
        Sepc:                target_o = sepc_i;
        PcOrReadDataPlusImm: target_o = branch_target_i;
        default:             target_o = pc_plus_4_i;
      endcase
    end
  end

endmodule

// File: rtl/pc_redirect_controller.sv
// Sequences branch/trap redirects into fetch: latch target, flush/stall, then drain wrong path.
// Optional BRANCH_STATS_EN adds taken/not-taken resolve counters.
module pc_redirect_controller
  import branch_decoder_unit_pkg::*;
  import pc_redirect_controller_pkg::*;
#(
  parameter int unsigned Width       = 64,
  parameter int unsigned DrainCycles = 2
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             resolve_valid_i,
  input  pc_src_t          pc_src_i,
  input  logic [Width-1:0] pc_plus_4_i,
  input  logic [Width-1:0] branch_target_i,
  input  logic [Width-1:0] mepc_i,
  input  logic [Width-1:0] sepc_i,
  input  logic             trap_req_i,
  input  logic [Width-1:0] trap_vector_i,
  input  logic             fetch_ready_i,
  output logic             redirect_valid_o,
  output logic [Width-1:0] redirect_pc_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             discard_fetch_o,
  output logic             busy_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_count_o,
  output logic [31:0]      not_taken_count_o
`endif
);

  localparam logic [DrainCntWidth-1:0] DrainInit =
      (DrainCycles == 0) ? '0 : DrainCntWidth'(DrainCycles - 1);

  state_t                   state_q, state_d;
  logic [DrainCntWidth-1:0] cnt_q, cnt_d;
  logic [Width-1:0]         pc_q, pc_d;
  logic                     valid_q, valid_d;
  logic                     flush_q, flush_d;
  logic                     stall_q, stall_d;
  logic                     discard_q, discard_d;
  logic [Width-1:0]         target;
  logic                     evt;
  logic                     handshake;

  redirect_target_mux #(
    .Width (Width)
  ) u_target_mux (
    .trap_req_i      (trap_req_i),
    .pc_src_i        (pc_src_i),
    .pc_plus_4_i     (pc_plus_4_i),
    .branch_target_i (branch_target_i),
    .mepc_i          (mepc_i),
    .sepc_i          (sepc_i),
    .trap_vector_i   (trap_vector_i),
    .target_o        (target)
  );

  assign evt       = is_redirect_event(trap_req_i, resolve_valid_i, pc_src_i);
  assign handshake = valid_q & fetch_ready_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    flush_d   = flush_q;
    stall_d   = stall_q;
    discard_d = discard_q;
    unique case (state_q)
      Idle: begin
        if (evt) begin
          state_d = Redirect;
          pc_d    = target;
          valid_d = 1'b1;
          flush_d = 1'b1;
          stall_d = 1'b1;
        end
      end
      Redirect: begin
        // A trap overrides the pending target; with a handshake the old target was consumed.
        if (trap_req_i) begin
          pc_d = target;
        end else if (handshake) begin
          valid_d = 1'b0;
          flush_d = 1'b0;
          stall_d = 1'b0;
          if (DrainCycles == 0) begin
            state_d = Idle;
          end else begin
            state_d   = Drain;
            cnt_d     = DrainInit;
            discard_d = 1'b1;
          end
        end
      end
      Drain: begin
        if (trap_req_i) begin
          state_d   = Redirect;
          pc_d      = target;
          valid_d   = 1'b1;
          flush_d   = 1'b1;
          stall_d   = 1'b1;
          discard_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d   = Idle;
          discard_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = Idle;
        valid_d   = 1'b0;
        flush_d   = 1'b0;
        stall_d   = 1'b0;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= Idle;
      cnt_q     <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
      stall_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      flush_q   <= flush_d;
      stall_q   <= stall_d;
      discard_q <= discard_d;
    end
  end

  assign redirect_valid_o = valid_q;
  assign redirect_pc_o    = pc_q;
  assign flush_o          = flush_q;
  assign stall_o          = stall_q;
  assign discard_fetch_o  = discard_q;
  assign busy_o           = (state_q != Idle);

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_q, taken_d;
  logic [31:0] not_taken_q, not_taken_d;

  // Only resolves seen in Idle are real; outside Idle the pipeline is being flushed.
  always_comb begin
    taken_d     = taken_q;
    not_taken_d = not_taken_q;
    if ((state_q == Idle) && resolve_valid_i) begin
      if (pc_src_i == PcOrReadDataPlusImm) taken_d = taken_q + 32'd1;
      if (pc_src_i == PcPlus4) not_taken_d = not_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  assign taken_count_o     = taken_q;
  assign not_taken_count_o = not_taken_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed bench with an expectation queue for pc_redirect_controller (DrainCycles 2 and 0).
module tb_pc_redirect_controller;
  import branch_decoder_unit_pkg::*;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         resolve_valid;
  pc_src_t      pc_src;
  logic [W-1:0] pc_plus_4, branch_target, mepc, sepc, trap_vector;
  logic         trap_req, fetch_ready;

  logic         rv, fl, st, df, bs;
  logic [W-1:0] rpc;
  logic         rv_z, fl_z, st_z, df_z, bs_z;
  logic [W-1:0] rpc_z;
`ifdef BRANCH_STATS_EN
  logic [31:0]  taken_cnt, not_taken_cnt, taken_cnt_z, not_taken_cnt_z;
`endif

  int vectors = 0;
  int miscompares = 0;
  int z_disc = 0;

  typedef struct {
    string        tag;
    bit           z;
    bit           chk_pc;
    logic         rv, fl, st, df, bs;
    logic [W-1:0] pc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_redirect_controller #(.Width(W), .DrainCycles(2)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .resolve_valid_i(resolve_valid), .pc_src_i(pc_src),
    .pc_plus_4_i(pc_plus_4), .branch_target_i(branch_target), .mepc_i(mepc), .sepc_i(sepc),
    .trap_req_i(trap_req), .trap_vector_i(trap_vector), .fetch_ready_i(fetch_ready),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .flush_o(fl), .stall_o(st),
    .discard_fetch_o(df), .busy_o(bs)
`ifdef BRANCH_STATS_EN
    , .taken_count_o(taken_cnt), .not_taken_count_o(not_taken_cnt)
`endif
  );

  pc_redirect_controller #(.Width(W), .DrainCycles(0)) dut_z (
    .clock_i(clk), .reset_n_i(rst_n), .resolve_valid_i(resolve_valid), .pc_src_i(pc_src),
    .pc_plus_4_i(pc_plus_4), .branch_target_i(branch_target), .mepc_i(mepc), .sepc_i(sepc),
    .trap_req_i(trap_req), .trap_vector_i(trap_vector), .fetch_ready_i(fetch_ready),
    .redirect_valid_o(rv_z), .redirect_pc_o(rpc_z), .flush_o(fl_z), .stall_o(st_z),
    .discard_fetch_o(df_z), .busy_o(bs_z)
`ifdef BRANCH_STATS_EN
    , .taken_count_o(taken_cnt_z), .not_taken_count_o(not_taken_cnt_z)
`endif
  );

  // The zero-drain build must never discard a fetch response.
  always @(negedge clk) if (rst_n === 1'b1 && df_z !== 1'b0) z_disc++;

  // Resolves are not expected while the controller is busy.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(resolve_valid && bs === 1'b1)) else begin
        miscompares++;
        $error("FAIL protocol resolve_valid while busy observed=1 required=0");
      end
    end
  end

  task automatic cmp(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(string tag, bit z, logic v, logic f, logic s, logic d, logic b,
                            logic [W-1:0] pc, bit chk_pc);
    exp_t e;
    e.tag = tag; e.z = z; e.rv = v; e.fl = f; e.st = s; e.df = d; e.bs = b;
    e.pc = pc; e.chk_pc = chk_pc;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.z) begin
        cmp({e.tag, ".z.rv"}, W'(rv_z), W'(e.rv));
        cmp({e.tag, ".z.flush"}, W'(fl_z), W'(e.fl));
        cmp({e.tag, ".z.stall"}, W'(st_z), W'(e.st));
        cmp({e.tag, ".z.discard"}, W'(df_z), W'(e.df));
        cmp({e.tag, ".z.busy"}, W'(bs_z), W'(e.bs));
        if (e.chk_pc) cmp({e.tag, ".z.pc"}, rpc_z, e.pc);
      end else begin
        cmp({e.tag, ".rv"}, W'(rv), W'(e.rv));
        cmp({e.tag, ".flush"}, W'(fl), W'(e.fl));
        cmp({e.tag, ".stall"}, W'(st), W'(e.st));
        cmp({e.tag, ".discard"}, W'(df), W'(e.df));
        cmp({e.tag, ".busy"}, W'(bs), W'(e.bs));
        if (e.chk_pc) cmp({e.tag, ".pc"}, rpc, e.pc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs while a redirect is pending, draining, or idle.
  task automatic exp_redirect(string tag, logic [W-1:0] pc);
    expect_out(tag, 1'b0, 1, 1, 1, 0, 1, pc, 1'b1);
  endtask
  task automatic exp_drain(string tag);
    expect_out(tag, 1'b0, 0, 0, 0, 1, 1, '0, 1'b0);
  endtask
  task automatic exp_idle(string tag);
    expect_out(tag, 1'b0, 0, 0, 0, 0, 0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; resolve_valid = 1'b0; pc_src = PcPlus4; trap_req = 1'b0;
    fetch_ready = 1'b0; pc_plus_4 = 64'h44; branch_target = '0; mepc = '0; sepc = '0;
    trap_vector = '0;
    step(); step();
    expect_out("reset", 1'b0, 0, 0, 0, 0, 0, '0, 1'b1);
    expect_out("reset", 1'b1, 0, 0, 0, 0, 0, '0, 1'b1);
    check();
    rst_n = 1'b1;
    step();

    // Taken branch with fetch ready immediately.
    branch_target = 64'h8000_0100; pc_src = PcOrReadDataPlusImm; resolve_valid = 1'b1;
    fetch_ready = 1'b1;
    step(); resolve_valid = 1'b0;
    exp_redirect("taken.t1", 64'h8000_0100); check();
    step(); exp_drain("taken.t2"); check();
    step(); exp_drain("taken.t3"); check();
    step(); exp_idle("taken.t4"); check();

    // Not-taken resolves do nothing.
    fetch_ready = 1'b0; pc_src = PcPlus4; resolve_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); exp_idle("nottaken"); check();
    end
    resolve_valid = 1'b0;
`ifdef BRANCH_STATS_EN
    cmp("stats.not_taken", W'(not_taken_cnt), W'(10));
    cmp("stats.taken", W'(taken_cnt), W'(1));
`endif

    // Mret under backpressure holds the target.
    mepc = 64'h1000; pc_src = Mepc; resolve_valid = 1'b1;
    step(); resolve_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_redirect("backpressure", 64'h1000); check();
      if (i < 4) step();
    end
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0; exp_drain("bp.drain1"); check();
    step(); exp_drain("bp.drain2"); check();
    step(); exp_idle("bp.idle"); check();

    // Sret overridden by a trap, then a trap aborts the drain.
    sepc = 64'h3000; pc_src = Sepc; resolve_valid = 1'b1;
    step(); resolve_valid = 1'b0;
    exp_redirect("sret", 64'h3000); check();
    trap_req = 1'b1; trap_vector = 64'h200;
    step(); trap_req = 1'b0; exp_redirect("trap.override", 64'h200); check();
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0; exp_drain("trap.drain"); check();
    trap_req = 1'b1;
    step(); trap_req = 1'b0; exp_redirect("trap.in_drain", 64'h200); check();
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0; exp_drain("trap.full1"); check();
    step(); exp_drain("trap.full2"); check();
    step(); exp_idle("trap.idle"); check();

    // Trap beats Mret in Idle; trap coinciding with handshake re-enters Redirect directly.
    trap_req = 1'b1; trap_vector = 64'h500; resolve_valid = 1'b1; pc_src = Mepc;
    step(); resolve_valid = 1'b0;
    exp_redirect("prio.trap", 64'h500); check();
    trap_vector = 64'h400; fetch_ready = 1'b1;
    step(); trap_req = 1'b0; exp_redirect("hs_trap", 64'h400); check();
    step(); fetch_ready = 1'b0; exp_drain("hs_trap.drain1"); check();
    step(); exp_drain("hs_trap.drain2"); check();
    step(); exp_idle("hs_trap.idle"); check();

    // Asynchronous reset mid-Redirect.
    branch_target = 64'h8000_0100; pc_src = PcOrReadDataPlusImm; resolve_valid = 1'b1;
    step(); resolve_valid = 1'b0;
    exp_redirect("prereset", 64'h8000_0100); check();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 0, 0, 0, 0, 0, '0, 1'b1);
    expect_out("async_reset", 1'b1, 0, 0, 0, 0, 0, '0, 1'b1);
    check();
    #1 rst_n = 1'b1;
    step();

    // Zero-drain build: handshake returns straight to Idle.
    fetch_ready = 1'b1; resolve_valid = 1'b1;
    step(); resolve_valid = 1'b0;
    expect_out("drain0.redirect", 1'b1, 1, 1, 1, 0, 1, 64'h8000_0100, 1'b1); check();
    step();
    expect_out("drain0.idle", 1'b1, 0, 0, 0, 0, 0, '0, 1'b0); check();
    fetch_ready = 1'b0;
    step(); step();
    exp_idle("final.idle"); check();
    cmp("drain0.no_discard", W'(z_disc), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
